// File: rtl/imem_uart_loader.sv
// imem_uart_loader
//   Loads a program image received over UART into the CPU instruction RAM
//   and holds the CPU in reset while the load is in progress.
//   Frame: 0xA5, LEN_LO, LEN_HI (N words), N x 4 little-endian data bytes,
//   then one checksum byte equal to the XOR of all 4N data bytes.
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   uart_rx     serial input, 8N1, LSB first, idle high, asynchronous to clk
//   load_en     level; rising edge starts a load, falling edge aborts/ends it
//   mem_addr    instruction memory word address
//   mem_wdata   instruction word to write
//   mem_wren    one-cycle write strobe
//   cpu_hold    high = keep the CPU in reset
//   busy        high while a frame is being received
//   done        image loaded and checksum matched
//   err         sticky: framing, bad length, bad checksum or abort
//   word_count  words written in the current/last load
module imem_uart_loader #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  input  logic              load_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_wren,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CPB   = CLK_HZ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int WC_W  = ADDR_W + 1;
  localparam logic [16:0] MAX_LEN = 17'(1 << ADDR_W);
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state, rx_state_n;
  logic             rx_sync_p0, rx_sync_p1, rx_sync_p2;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_valid, rx_valid_n;
  logic             rx_ferr, rx_ferr_n;
  logic [7:0]       rx_byte;

  // rx_sync_p1 is the synchronised line; rx_sync_p2 is its previous value
  // and is used only for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_sync_p2 <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_valid   <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      rx_sync_p0 <= uart_rx;
      rx_sync_p1 <= rx_sync_p0;
      rx_sync_p2 <= rx_sync_p1;
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      rx_valid   <= rx_valid_n;
      rx_ferr    <= rx_ferr_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_valid_n = 1'b0;
    rx_ferr_n  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_sync_p2 && !rx_sync_p1) begin
          rx_state_n = RX_START;
          rx_cnt_n   = CNT_W'(HALF - 1);
        end
      end
      RX_START: begin
        // Re-check the line half a bit later to reject short glitches.
        if (rx_cnt == '0) begin
          if (!rx_sync_p1) begin
            rx_state_n = RX_DATA;
            rx_cnt_n   = CNT_W'(CPB - 1);
            rx_bit_n   = 3'd0;
          end else begin
            rx_state_n = RX_IDLE;
          end
        end else begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_n = {rx_sync_p1, rx_shift[7:1]};
          rx_cnt_n   = CNT_W'(CPB - 1);
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        // Back to idle mid stop bit so the next start edge is never missed.
        if (rx_cnt == '0) begin
          rx_valid_n = rx_sync_p1;
          rx_ferr_n  = !rx_sync_p1;
          rx_state_n = RX_IDLE;
        end else begin
          rx_cnt_n = rx_cnt - CNT_W'(1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign rx_byte = rx_shift;

  // ---------------------------------------------------------------------
  // Frame parser / memory writer
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t          state, state_n;
  logic            load_q;
  logic [7:0]      len_lo;
  logic [15:0]     len_full;
  logic            len_bad;
  logic [WC_W-1:0] n_words;
  logic [WC_W-1:0] wc_inc;
  logic [1:0]      byte_idx;
  logic [23:0]     word_buf;
  logic [7:0]      csum;
  logic            active;
  logic            start_load;
  logic            abort;
  logic            byte_ok;

  assign active     = (state == S_SYNC) || (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA) || (state == S_CSUM);
  assign start_load = (state == S_IDLE) && load_en && !load_q;
  assign abort      = active && !load_en;
  assign byte_ok    = rx_valid && !abort;
  assign len_full   = {rx_byte, len_lo};
  assign len_bad    = (len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN);
  assign wc_inc     = word_count + WC_W'(1);

  assign busy     = active;
  assign cpu_hold = active || (state == S_ERROR);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (start_load) state_n = S_SYNC;
      S_SYNC:   if (rx_valid && rx_byte == SYNC_BYTE) state_n = S_LEN_LO;
      S_LEN_LO: if (rx_valid) state_n = S_LEN_HI;
      S_LEN_HI: if (rx_valid) state_n = len_bad ? S_ERROR : S_DATA;
      S_DATA:   if (rx_valid && byte_idx == 2'd3 && wc_inc == n_words) state_n = S_CSUM;
      S_CSUM:   if (rx_valid) state_n = (rx_byte == csum) ? S_DONE : S_ERROR;
      S_DONE:   if (!load_en) state_n = S_IDLE;
      S_ERROR:  if (!load_en) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (active && rx_ferr) state_n = S_ERROR;
    // Dropping load_en mid-frame wins over anything the receiver reports.
    if (abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      load_q     <= 1'b0;
      len_lo     <= '0;
      n_words    <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      csum       <= '0;
      word_count <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state    <= state_n;
      load_q   <= load_en;
      mem_wren <= 1'b0;
      if (start_load) begin
        err        <= 1'b0;
        done       <= 1'b0;
        word_count <= '0;
        csum       <= '0;
        byte_idx   <= '0;
      end
      if (byte_ok) begin
        case (state)
          S_LEN_LO: len_lo  <= rx_byte;
          S_LEN_HI: n_words <= len_full[ADDR_W:0];
          S_DATA: begin
            csum     <= csum ^ rx_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_wren   <= 1'b1;
              mem_addr   <= word_count[ADDR_W-1:0];
              mem_wdata  <= {rx_byte, word_buf};
              word_count <= wc_inc;
            end else begin
              // After three bytes word_buf holds {b2, b1, b0}.
              word_buf <= {rx_byte, word_buf[23:8]};
            end
          end
          default: ;
        endcase
      end
      if (abort || (state_n == S_ERROR && state != S_ERROR)) err <= 1'b1;
      if (state == S_CSUM && state_n == S_DONE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: drives UART frames at 16 clocks per bit and
// compares every memory write and the end-of-load status against a
// byte-level frame model.
module tb_imem_uart_loader;
  localparam int ADDR_W = 11;
  localparam int CPB    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              uart_rx;
  logic              load_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_wren;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  always #5 clk = ~clk;

  imem_uart_loader #(.CLK_HZ(1600), .BAUD(100), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .load_en(load_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t exp_q[$];
  wr_t cap_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  function automatic logic [31:0] cap_data(input int idx);
    if (idx < cap_q.size()) return cap_q[idx].data;
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] cap_addr(input int idx);
    if (idx < cap_q.size()) return 32'(cap_q[idx].addr);
    return 32'hxxxx_xxxx;
  endfunction

  // Every write strobe must match the next write the model predicted.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_wren) begin
        cap_q.push_back('{int'(mem_addr), mem_wdata});
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_wren: addr %0d data 0x%08h, expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wren_addr", 32'(mem_addr), 32'(e.addr));
          check("wren_data", mem_wdata, e.data);
          check_bit("wren_hold", cpu_hold, 1'b1);
        end
      end
    end
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: run exceeded 60000 cycles, expected completion");
    $fatal(1, "timeout");
  end

  // Frame model: parses the byte stream the DUT will receive cleanly.
  // ev = an error event (framing error or abort) follows the last byte.
  task automatic model(input logic [7:0] bs[$], input bit ev,
                       output bit m_done, output bit m_err, output int m_wc);
    int i;
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_wc   = 0;
    x      = 8'h00;
    i      = 0;
    while (i < bs.size() && bs[i] != 8'hA5) i++;
    if (i + 2 >= bs.size()) begin m_err = ev; return; end
    n = {bs[i+2], bs[i+1]};
    i += 3;
    if (n == 0 || n > (1 << ADDR_W)) begin m_err = 1'b1; return; end
    for (int k = 0; k < n; k++) begin
      if (i + 3 >= bs.size()) begin m_err = ev; return; end
      w = {bs[i+3], bs[i+2], bs[i+1], bs[i]};
      x = x ^ bs[i] ^ bs[i+1] ^ bs[i+2] ^ bs[i+3];
      exp_q.push_back('{m_wc, w});
      m_wc++;
      i += 4;
    end
    if (i >= bs.size()) begin m_err = ev; return; end
    if (bs[i] == x) m_done = 1'b1;
    else            m_err  = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i], 1'b1);
  endtask

  task automatic start_load(input string tag);
    cap_q.delete();
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    load_en = 1'b1;
    repeat (2) @(negedge clk);
    check_bit({tag, "_start_hold"}, cpu_hold, 1'b1);
    check_bit({tag, "_start_busy"}, busy, 1'b1);
    check_bit({tag, "_start_done"}, done, 1'b0);
    check_bit({tag, "_start_err"}, err, 1'b0);
    check({tag, "_start_wc"}, 32'(word_count), 32'd0);
  endtask

  task automatic check_end(input string tag, input bit m_done, input bit m_err, input int m_wc);
    repeat (4) @(negedge clk);
    check_bit({tag, "_done"}, done, m_done);
    check_bit({tag, "_err"}, err, m_err);
    check({tag, "_wc"}, 32'(word_count), 32'(m_wc));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic end_load();
    load_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] f[$];
    bit md, me;
    int mw;

    rst = 1'b1; load_en = 1'b0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check_bit("rst_wren", mem_wren, 1'b0);
    check_bit("rst_hold", cpu_hold, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check("rst_wc", 32'(word_count), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean two-word load
    f = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    model(f, 1'b0, md, me, mw);
    start_load("t1");
    send_frame(f);
    check_end("t1", md, me, mw);
    check("t1_lit_w0", cap_data(0), 32'h1234_5678);
    check("t1_lit_a1", cap_addr(1), 32'd1);
    check("t1_lit_w1", cap_data(1), 32'hDEAD_BEEF);
    check("t1_lit_wc", 32'(word_count), 32'd2);
    check_bit("t1_lit_done", done, 1'b1);
    check_bit("t1_hold_done", cpu_hold, 1'b0);
    check_bit("t1_busy_done", busy, 1'b0);
    end_load();
    check_bit("t1_done_kept", done, 1'b1);
    check_bit("t1_idle_hold", cpu_hold, 1'b0);

    // Bad checksum
    f[11] = 8'h00;
    model(f, 1'b0, md, me, mw);
    start_load("t2");
    send_frame(f);
    check_end("t2", md, me, mw);
    check("t2_lit_writes", 32'(cap_q.size()), 32'd2);
    check_bit("t2_lit_err", err, 1'b1);
    check_bit("t2_hold_err", cpu_hold, 1'b1);
    end_load();
    check_bit("t2_release_hold", cpu_hold, 1'b0);
    check_bit("t2_err_sticky", err, 1'b1);

    // Sync hunt
    f = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    model(f, 1'b0, md, me, mw);
    start_load("t3");
    send_frame(f);
    check_end("t3", md, me, mw);
    check("t3_lit_writes", 32'(cap_q.size()), 32'd1);
    check("t3_lit_a0", cap_addr(0), 32'd0);
    check("t3_lit_w0", cap_data(0), 32'h0000_0001);
    check_bit("t3_lit_done", done, 1'b1);
    end_load();

    // Glitches and framing error on the second data word
    f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    model(f, 1'b1, md, me, mw);
    start_load("t4");
    uart_rx = 1'b0;
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    for (int i = 0; i < 7; i++) send_byte(f[i], 1'b1);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_bit("t4_glitch_busy", busy, 1'b1);
    send_byte(f[7], 1'b1);
    send_byte(8'h66, 1'b0);
    check_end("t4", md, me, mw);
    check("t4_lit_writes", 32'(cap_q.size()), 32'd1);
    check("t4_lit_w0", cap_data(0), 32'h4433_2211);
    check_bit("t4_hold_err", cpu_hold, 1'b1);
    end_load();

    // Length 0 and length 2^ADDR_W + 1 are rejected
    f = '{8'hA5, 8'h00, 8'h00};
    model(f, 1'b0, md, me, mw);
    start_load("t5a");
    send_frame(f);
    check_end("t5a", md, me, mw);
    check_bit("t5a_busy", busy, 1'b0);
    check_bit("t5a_hold", cpu_hold, 1'b1);
    end_load();
    f = '{8'hA5, 8'h01, 8'h08};
    model(f, 1'b0, md, me, mw);
    start_load("t5b");
    send_frame(f);
    check_end("t5b", md, me, mw);
    check_bit("t5b_lit_err", err, 1'b1);
    end_load();
    // Length exactly 2^ADDR_W is accepted; then aborted
    start_load("t5c");
    send_frame('{8'hA5, 8'h00, 8'h08});
    repeat (4) @(negedge clk);
    check_bit("t5c_max_busy", busy, 1'b1);
    check_bit("t5c_max_err", err, 1'b0);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    check_bit("t5c_abort_err", err, 1'b1);
    check_bit("t5c_abort_hold", cpu_hold, 1'b0);

    // Abort after six payload bytes
    f = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
    model(f, 1'b1, md, me, mw);
    start_load("t6");
    send_frame(f);
    load_en = 1'b0;
    @(negedge clk);
    check_bit("t6_abort_hold", cpu_hold, 1'b0);
    check_bit("t6_abort_err", err, 1'b1);
    check_end("t6", md, me, mw);
    check("t6_lit_writes", 32'(cap_q.size()), 32'd1);

    // Reset mid-frame, then a clean load
    start_load("t7");
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h78});
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_addr", 32'(mem_addr), 32'd0);
    check("t7_rst_wdata", mem_wdata, 32'd0);
    check_bit("t7_rst_hold", cpu_hold, 1'b1 ^ 1'b1);
    check_bit("t7_rst_busy", busy, 1'b0);
    check_bit("t7_rst_err", err, 1'b0);
    check("t7_rst_wc", 32'(word_count), 32'd0);
    uart_rx = 1'b1;
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    f = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    model(f, 1'b0, md, me, mw);
    start_load("t8");
    send_frame(f);
    check_end("t8", md, me, mw);
    check("t8_lit_w1", cap_data(1), 32'hDEAD_BEEF);
    check_bit("t8_lit_done", done, 1'b1);
    end_load();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
